// File: rtl/vjtag_dmi_if.sv
// Request/response port between the virtual-JTAG bridge and the debug module.
// The master side issues requests and accepts responses.
interface vjtag_dmi_if #(
    parameter int ADDR_W = 7
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/vjtag_dmi_bridge.sv
// Sequencer for a 1-bit-IR virtual JTAG tap: IDCODE on IR=0, and a
// {addr, data, op} access register on IR=1 that drives one bus transaction per update.
//
// state | meaning
// IDLE  | no transaction in flight, updates may launch a request
// REQ   | req_valid high, address/data/write held until req_ready
// RESP  | resp_ready high, waiting for resp_valid
module vjtag_dmi_bridge #(
    parameter logic [31:0] IDCODE = 32'h1000_0E31,
    parameter int          ADDR_W = 7
) (
    input  logic tck,
    input  logic reset_n,
    input  logic tdi,
    output logic tdo,
    input  logic ir_in,
    output logic ir_out,
    input  logic virtual_state_cdr,
    input  logic virtual_state_sdr,
    input  logic virtual_state_udr,
    input  logic jtag_state_tlr,
    output logic busy,
    vjtag_dmi_if.master dmi
);
    localparam int DR_W = ADDR_W + 34;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t            state;
    logic [DR_W-1:0]   sr;
    logic [ADDR_W-1:0] req_addr_q;
    logic [31:0]       req_wdata_q;
    logic              req_write_q;
    logic [ADDR_W-1:0] last_addr;
    logic [31:0]       last_rdata;
    logic [1:0]        sticky;
    logic              pend_err;

    logic [1:0]  sticky_nxt;
    logic        pend_nxt;
    logic [1:0]  op;
    logic        op_rw;
    logic        upd_hit;
    logic        accept;
    logic        resp_done;
    logic        err_evt;
    logic [1:0]  cap_status;

    assign busy           = (state != IDLE);
    assign ir_out         = busy;
    assign tdo            = sr[0];
    assign dmi.req_valid  = (state == REQ);
    assign dmi.resp_ready = (state == RESP);
    assign dmi.req_addr   = req_addr_q;
    assign dmi.req_wdata  = req_wdata_q;
    assign dmi.req_write  = req_write_q;

    assign op         = sr[1:0];
    assign op_rw      = (op == 2'b01) || (op == 2'b10);
    assign upd_hit    = virtual_state_udr && ir_in;
    assign accept     = upd_hit && op_rw && !busy && (sticky == 2'b00);
    assign resp_done  = (state == RESP) && dmi.resp_valid;
    assign err_evt    = pend_err || (resp_done && dmi.resp_err);
    assign cap_status = busy ? 2'b11 : sticky;

    // An error that completes during TLR is parked in pend_err and folded in once TLR drops.
    always_comb begin
        sticky_nxt = sticky;
        pend_nxt   = 1'b0;
        if (jtag_state_tlr) begin
            sticky_nxt = 2'b00;
            pend_nxt   = err_evt;
        end else begin
            if (err_evt && (sticky != 2'b11))
                sticky_nxt = 2'b10;
            if (upd_hit) begin
                if (op == 2'b11)
                    sticky_nxt = 2'b00;
                else if (op_rw && busy)
                    sticky_nxt = 2'b11;
            end
        end
    end

    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            sr          <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_write_q <= 1'b0;
            last_addr   <= '0;
            last_rdata  <= '0;
            sticky      <= 2'b00;
            pend_err    <= 1'b0;
        end else begin
            sticky   <= sticky_nxt;
            pend_err <= pend_nxt;

            if (jtag_state_tlr) begin
                sr <= '0;
            end else if (virtual_state_cdr) begin
                if (ir_in)
                    sr <= {last_addr, last_rdata, cap_status};
                else
                    sr <= {{(DR_W-32){1'b0}}, IDCODE};
            end else if (virtual_state_sdr) begin
                if (ir_in)
                    sr <= {tdi, sr[DR_W-1:1]};
                else
                    sr[31:0] <= {tdi, sr[31:1]};
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        req_addr_q  <= sr[DR_W-1 -: ADDR_W];
                        req_wdata_q <= sr[33:2];
                        req_write_q <= (op == 2'b10);
                        last_addr   <= sr[DR_W-1 -: ADDR_W];
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (dmi.req_ready)
                        state <= RESP;
                end
                RESP: begin
                    if (dmi.resp_valid) begin
                        if (!req_write_q)
                            last_rdata <= dmi.resp_rdata;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vjtag_dmi_bridge.sv
// Directed bench for vjtag_dmi_bridge: a transaction table plus hand sequences
// for busy violation, sticky clear, mid-transaction reset and TLR.
module tb_vjtag_dmi_bridge;
    logic tck = 1'b0;
    logic reset_n = 1'b0;
    logic tdi = 1'b0;
    logic tdo;
    logic ir_in = 1'b0;
    logic ir_out;
    logic cdr = 1'b0, sdr = 1'b0, udr = 1'b0, tlr = 1'b0;
    logic busy;

    vjtag_dmi_if #(.ADDR_W(7)) dmi ();

    vjtag_dmi_bridge dut (
        .tck               (tck),
        .reset_n           (reset_n),
        .tdi               (tdi),
        .tdo               (tdo),
        .ir_in             (ir_in),
        .ir_out            (ir_out),
        .virtual_state_cdr (cdr),
        .virtual_state_sdr (sdr),
        .virtual_state_udr (udr),
        .jtag_state_tlr    (tlr),
        .busy              (busy),
        .dmi               (dmi)
    );

    always #5 tck = ~tck;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          rdy_dly;
        int          rsp_dly;
        logic [6:0]  exp_addr;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_status;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic do_access(input logic [1:0] op, input logic [6:0] addr,
                             input logic [31:0] data, output logic [40:0] cap);
        logic [40:0] din;
        din   = {addr, data, op};
        ir_in = 1'b1;
        cdr   = 1'b1;
        tick();
        cdr = 1'b0;
        for (int i = 0; i < 41; i++) begin
            cap[i] = tdo;
            tdi    = din[i];
            sdr    = 1'b1;
            tick();
        end
        sdr = 1'b0;
        tdi = 1'b0;
        udr = 1'b1;
        tick();
        udr = 1'b0;
    endtask

    task automatic complete(input logic [31:0] rdata, input logic err);
        int guard;
        guard = 0;
        dmi.req_ready = 1'b1;
        while (!dmi.resp_ready && guard < 20) begin
            tick();
            guard++;
        end
        dmi.req_ready = 1'b0;
        chk("resp_ready_wait", {63'd0, dmi.resp_ready}, 64'd1);
        dmi.resp_valid = 1'b1;
        dmi.resp_rdata = rdata;
        dmi.resp_err   = err;
        tick();
        dmi.resp_valid = 1'b0;
        dmi.resp_err   = 1'b0;
    endtask

    initial begin
        logic [40:0] cap;
        logic [31:0] idc;
        int vcnt;
        int guard;

        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [40:0] cap;
        logic [31:0] idc;
        int vcnt;
        int guard;

        dmi.req_ready  = 1'b0;
        dmi.resp_valid = 1'b0;
        dmi.resp_rdata = '0;
        dmi.resp_err   = 1'b0;

        vecs[0] = '{2'b10, 7'h10, 32'hDEADBEEF, 32'h0000_0055, 1'b0, 1, 3, 7'h10, 32'h0000_0000, 2'b00};
        vecs[1] = '{2'b01, 7'h11, 32'h0000_0000, 32'h0000_00A5, 1'b0, 0, 1, 7'h11, 32'h0000_00A5, 2'b00};
        vecs[2] = '{2'b10, 7'h22, 32'h1234_5678, 32'hFFFF_0000, 1'b1, 2, 0, 7'h22, 32'h0000_00A5, 2'b10};
        vecs[3] = '{2'b01, 7'h7F, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0, 7'h7F, 32'hFFFF_FFFF, 2'b00};
        vecs[4] = '{2'b01, 7'h05, 32'hCAFE_0000, 32'h0BAD_F00D, 1'b1, 3, 2, 7'h05, 32'h0BAD_F00D, 2'b10};
        vecs[5] = '{2'b10, 7'h00, 32'h0000_0000, 32'h1111_1111, 1'b0, 0, 0, 7'h00, 32'h0BAD_F00D, 2'b00};

        repeat (3) tick();
        chk("rst_tdo",        {63'd0, tdo},            64'd0);
        chk("rst_req_valid",  {63'd0, dmi.req_valid},  64'd0);
        chk("rst_resp_ready", {63'd0, dmi.resp_ready}, 64'd0);
        chk("rst_busy",       {63'd0, busy},           64'd0);
        chk("rst_ir_out",     {63'd0, ir_out},         64'd0);
        reset_n = 1'b1;
        tick();

        // IDCODE scan
        ir_in = 1'b0;
        cdr   = 1'b1;
        tick();
        cdr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            idc[i] = tdo;
            tdi    = 1'b0;
            sdr    = 1'b1;
            tick();
        end
        sdr = 1'b0;
        chk("idcode", {32'd0, idc}, {32'd0, 32'h1000_0E31});

        foreach (vecs[v]) begin
            do_access(vecs[v].op, vecs[v].addr, vecs[v].wdata, cap);
            vcnt  = 0;
            guard = 0;
            while (dmi.req_valid && guard < 20) begin
                vcnt++;
                guard++;
                chk("req_write", {63'd0, dmi.req_write}, {63'd0, vecs[v].op == 2'b10});
                chk("req_addr",  {57'd0, dmi.req_addr},  {57'd0, vecs[v].addr});
                chk("req_wdata", {32'd0, dmi.req_wdata}, {32'd0, vecs[v].wdata});
                chk("ir_out_req", {63'd0, ir_out}, 64'd1);
                dmi.req_ready = (vcnt > vecs[v].rdy_dly);
                tick();
            end
            dmi.req_ready = 1'b0;
            chk("req_valid_cycles", 64'(vcnt), 64'(vecs[v].rdy_dly + 1));
            for (int k = 0; k < vecs[v].rsp_dly; k++) begin
                chk("resp_ready_hold", {62'd0, dmi.resp_ready, dmi.req_valid}, 64'd2);
                tick();
            end
            chk("busy_resp", {63'd0, busy}, 64'd1);
            dmi.resp_valid = 1'b1;
            dmi.resp_rdata = vecs[v].rdata;
            dmi.resp_err   = vecs[v].err;
            tick();
            dmi.resp_valid = 1'b0;
            dmi.resp_err   = 1'b0;
            chk("busy_after",   {63'd0, busy},   64'd0);
            chk("ir_out_after", {63'd0, ir_out}, 64'd0);
            do_access(2'b11, 7'h00, 32'h0, cap);
            chk("capture", {23'd0, cap},
                {23'd0, vecs[v].exp_addr, vecs[v].exp_rdata, vecs[v].exp_status});
        end

        // busy violation, sticky hold, explicit clear
        do_access(2'b01, 7'h33, 32'h0, cap);
        chk("bv_req_valid", {63'd0, dmi.req_valid}, 64'd1);
        do_access(2'b01, 7'h44, 32'h0, cap);
        chk("bv_cap_busy",  {62'd0, cap[1:0]}, 64'd3);
        chk("bv_addr_kept", {57'd0, dmi.req_addr}, {57'd0, 7'h33});
        complete(32'h0000_0077, 1'b0);
        do_access(2'b01, 7'h55, 32'h0, cap);
        chk("bv_sticky", {23'd0, cap}, {23'd0, 7'h33, 32'h0000_0077, 2'b11});
        tick();
        chk("bv_dropped", {62'd0, busy, dmi.req_valid}, 64'd0);
        do_access(2'b11, 7'h00, 32'h0, cap);
        chk("bv_sticky_kept", {23'd0, cap}, {23'd0, 7'h33, 32'h0000_0077, 2'b11});
        do_access(2'b01, 7'h66, 32'h0, cap);
        chk("bv_cleared", {23'd0, cap}, {23'd0, 7'h33, 32'h0000_0077, 2'b00});
        chk("bv_new_req", {56'd0, dmi.req_valid, dmi.req_addr}, {56'd0, 1'b1, 7'h66});
        complete(32'h0000_0099, 1'b0);
        do_access(2'b00, 7'h00, 32'h0, cap);
        chk("bv_final", {23'd0, cap}, {23'd0, 7'h66, 32'h0000_0099, 2'b00});

        // reset while a request is pending
        do_access(2'b01, 7'h12, 32'h0, cap);
        chk("mr_pre", {61'd0, dmi.req_valid, busy, tdo}, 64'd7);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mr_async", {61'd0, dmi.req_valid, busy, tdo}, 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        do_access(2'b11, 7'h00, 32'h0, cap);
        chk("mr_capture", {23'd0, cap}, 64'd0);

        // TLR clears the shift register
        chk("tlr_pre_tdo", {63'd0, tdo}, 64'd1);
        tlr = 1'b1;
        tick();
        tlr = 1'b0;
        chk("tlr_tdo", {63'd0, tdo}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
